// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM state encoding, default frame geometry and the
// mid-bit sample tick positions used by the majority voter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   localparam int unsigned DEF_DATA_BITS  = 8;
   localparam int unsigned DEF_OVERSAMPLE = 16;

   localparam int unsigned SAMP_EARLY = DEF_OVERSAMPLE / 2 - 1;
   localparam int unsigned SAMP_MID   = DEF_OVERSAMPLE / 2;
   localparam int unsigned SAMP_LATE  = DEF_OVERSAMPLE / 2 + 1;

   // k = 0,1,2 gives the early/mid/late sample tick for any oversample ratio
   function automatic int unsigned samp_tick(input int unsigned os, input int unsigned k);
      return os / 2 - 1 + k;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: rx input synchroniser plus a 3-deep sample register whose
// 2-of-3 majority (including the sample being taken this clk) is the voted bit.
module uart_rx_sampler #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   input  logic samp_en,
   output logic rx_sync,
   output logic bit_vote
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [2:0]             samp_q, samp_d;

   always_comb begin
      sync_d[0] = rx;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      samp_d   = samp_en ? {samp_q[1:0], rx_sync} : samp_q;
      // voting on the next-state value lets a decision on the late tick see all three samples
      bit_vote = (samp_d[0] & samp_d[1]) | (samp_d[0] & samp_d[2]) | (samp_d[1] & samp_d[2]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         samp_q <= '1;
      end else begin
         sync_q <= sync_d;
         samp_q <= samp_d;
      end
   end

   assign rx_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling UART receiver with framing check and valid/ready output.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
   parameter int unsigned OVERSAMPLE  = DEF_OVERSAMPLE,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PARITY_ODD  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 os_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   localparam int unsigned TW      = $clog2(OVERSAMPLE);
   localparam int unsigned BW      = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_EARLY = TW'(samp_tick(OVERSAMPLE, 0));
   localparam logic [TW-1:0] T_MID   = TW'(samp_tick(OVERSAMPLE, 1));
   localparam logic [TW-1:0] T_LATE  = TW'(samp_tick(OVERSAMPLE, 2));
   localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);
   localparam bit ODD = (PARITY_ODD != 0);

   rx_state_e              state_q, state_d;
   logic [TW-1:0]          tick_q, tick_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   par_q, par_d;
   logic                   valid_q, valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   parity_err_q, parity_err_d;
   logic                   overrun_q, overrun_d;
   logic                   samp_en, rx_sync, bit_vote, deliver, tick_last, par_bad;

   uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .samp_en  (samp_en),
      .rx_sync  (rx_sync),
      .bit_vote (bit_vote)
   );

   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      par_d        = par_q;
      data_d       = data_q;
      valid_d      = valid_q;
      overrun_d    = overrun_q;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      deliver      = 1'b0;
      samp_en      = 1'b0;
      tick_last    = (tick_q == T_LAST);
      par_bad      = (((^shift_q) ^ par_q) != ODD);

      if (valid_q && ready) valid_d = 1'b0;

      if (!en) begin
         state_d   = ST_IDLE;
         tick_d    = '0;
         bit_d     = '0;
         overrun_d = 1'b0;
      end else if (os_tick) begin
         if (state_q != ST_IDLE) begin
            tick_d  = tick_last ? '0 : tick_q + 1'b1;
            samp_en = (tick_q == T_EARLY) || (tick_q == T_MID) || (tick_q == T_LATE);
         end
         case (state_q)
            ST_IDLE: begin
               if (!rx_sync) begin
                  state_d = ST_START;
                  tick_d  = '0;
               end
            end
            ST_START: begin
               if (tick_last) begin
                  if (bit_vote) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DATA;
                     bit_d   = '0;
                  end
               end
            end
            ST_DATA: begin
               if (tick_last) begin
                  shift_d = {bit_vote, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == B_LAST) state_d = PAR_EN ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               if (tick_last) begin
                  par_d   = bit_vote;
                  state_d = ST_STOP;
               end
            end
            ST_STOP: begin
               // half stop bit: deciding early leaves time to resync on the next start edge
               if (tick_q == T_LATE) begin
                  state_d = ST_IDLE;
                  if (!bit_vote)             frame_err_d  = 1'b1;
                  else if (PAR_EN && par_bad) parity_err_d = 1'b1;
                  else                       deliver      = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (deliver) begin
            if (!valid_q || ready) begin
               data_d  = shift_q;
               valid_d = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         tick_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data_out   = data_q;
   assign valid      = valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frames through uart_rx_os at 16x oversampling, one task per scenario.
// The parity scenario is included when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_os;

   localparam int unsigned DB       = 8;
   localparam int unsigned OS       = 16;
   localparam int unsigned CPT      = 4;
   localparam int unsigned BIT_CLKS = OS * CPT;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b1;
   logic          os_tick = 1'b0;
   logic          rx = 1'b1;
   logic          ready = 1'b1;
   logic [DB-1:0] data_out;
   logic          valid, frame_err, parity_err, overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int v_cycles = 0;
   int fe_cycles = 0;
   int pe_cycles = 0;
   logic [DB-1:0] got[$];
   logic valid_prev = 1'b0;

   uart_rx_os #(.DATA_BITS(DB), .OVERSAMPLE(OS), .SYNC_STAGES(2), .PARITY_ODD(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .os_tick    (os_tick),
      .rx         (rx),
      .data_out   (data_out),
      .valid      (valid),
      .ready      (ready),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (CPT - 1) @(posedge clk);
         #1 os_tick = 1'b1;
         @(posedge clk);
         #1 os_tick = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (valid === 1'b1 && valid_prev !== 1'b1) got.push_back(data_out);
      if (valid === 1'b1) v_cycles++;
      if (frame_err === 1'b1) fe_cycles++;
      if (parity_err === 1'b1) pe_cycles++;
      valid_prev = valid;
   end

   task automatic clear_mon();
      got.delete();
      v_cycles = 0;
      fe_cycles = 0;
      pe_cycles = 0;
   endtask

   task automatic wait_clks(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      wait_clks(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [DB-1:0] b, input logic stop_b, input bit has_par, input logic par_b);
      send_bit(1'b0);
      for (int i = 0; i < DB; i++) send_bit(b[i]);
      if (has_par) send_bit(par_b);
      send_bit(stop_b);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; ready = 1'b1; rx = 1'b1;
      wait_clks(4);
      if (data_out !== 8'h00) begin $display("FAIL reset_data: got %h want 00", data_out); n_fail++; end n_tests++;
      if (valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", valid); n_fail++; end n_tests++;
      if (frame_err !== 1'b0) begin $display("FAIL reset_frame_err: got %b want 0", frame_err); n_fail++; end n_tests++;
      if (parity_err !== 1'b0) begin $display("FAIL reset_parity_err: got %b want 0", parity_err); n_fail++; end n_tests++;
      if (overrun !== 1'b0) begin $display("FAIL reset_overrun: got %b want 0", overrun); n_fail++; end n_tests++;
      rst = 1'b0;
      wait_clks(BIT_CLKS);
   endtask

   task automatic test_good_byte();
      ready = 1'b1;
      clear_mon();
      send_frame(8'hB4, 1'b1, 1'b0, 1'b0);
      wait_clks(2 * BIT_CLKS);
      if (got.size() != 1) begin $display("FAIL good_count: got %0d want 1", got.size()); n_fail++; end n_tests++;
      if (got.size() > 0 && got[0] !== 8'hB4) begin $display("FAIL good_byte: got %h want b4", got[0]); n_fail++; end n_tests++;
      if (v_cycles != 1) begin $display("FAIL good_valid_width: got %0d want 1", v_cycles); n_fail++; end n_tests++;
      if (fe_cycles != 0 || pe_cycles != 0) begin $display("FAIL good_errors: got fe=%0d pe=%0d want 0 0", fe_cycles, pe_cycles); n_fail++; end n_tests++;
      if (data_out !== 8'hB4) begin $display("FAIL good_data_hold: got %h want b4", data_out); n_fail++; end n_tests++;
      if (valid !== 1'b0) begin $display("FAIL good_valid_clear: got %b want 0", valid); n_fail++; end n_tests++;
   endtask

   task automatic test_glitch();
      clear_mon();
      rx = 1'b0;
      wait_clks(4 * CPT);
      rx = 1'b1;
      wait_clks(3 * BIT_CLKS);
      if (v_cycles != 0) begin $display("FAIL glitch_valid: got %0d cycles want 0", v_cycles); n_fail++; end n_tests++;
      if (fe_cycles != 0 || pe_cycles != 0) begin $display("FAIL glitch_errors: got fe=%0d pe=%0d want 0 0", fe_cycles, pe_cycles); n_fail++; end n_tests++;
      if (data_out !== 8'hB4) begin $display("FAIL glitch_data: got %h want b4", data_out); n_fail++; end n_tests++;
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
      wait_clks(2 * BIT_CLKS);
      if (got.size() != 1 || got[0] !== 8'h0F) begin $display("FAIL glitch_recover: got n=%0d data=%h want n=1 data=0f", got.size(), data_out); n_fail++; end n_tests++;
   endtask

   task automatic test_frame_err();
      clear_mon();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      wait_clks(2 * BIT_CLKS);
      if (fe_cycles != 1) begin $display("FAIL ferr_pulse: got %0d cycles want 1", fe_cycles); n_fail++; end n_tests++;
      if (v_cycles != 0) begin $display("FAIL ferr_valid: got %0d cycles want 0", v_cycles); n_fail++; end n_tests++;
      if (data_out !== 8'h0F) begin $display("FAIL ferr_data: got %h want 0f", data_out); n_fail++; end n_tests++;
      if (pe_cycles != 0) begin $display("FAIL ferr_parity: got %0d want 0", pe_cycles); n_fail++; end n_tests++;
   endtask

   task automatic test_overrun();
      ready = 1'b0;
      clear_mon();
      send_frame(8'hB4, 1'b1, 1'b0, 1'b0);
      wait_clks(BIT_CLKS);
      if (valid !== 1'b1 || data_out !== 8'hB4) begin $display("FAIL ovr_first: got valid=%b data=%h want 1 b4", valid, data_out); n_fail++; end n_tests++;
      if (overrun !== 1'b0) begin $display("FAIL ovr_early: got %b want 0", overrun); n_fail++; end n_tests++;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      wait_clks(2 * BIT_CLKS);
      if (data_out !== 8'hB4) begin $display("FAIL ovr_data_kept: got %h want b4", data_out); n_fail++; end n_tests++;
      if (valid !== 1'b1) begin $display("FAIL ovr_valid: got %b want 1", valid); n_fail++; end n_tests++;
      if (overrun !== 1'b1) begin $display("FAIL ovr_flag: got %b want 1", overrun); n_fail++; end n_tests++;
      en = 1'b0;
      wait_clks(2);
      if (overrun !== 1'b0) begin $display("FAIL ovr_en_clear: got %b want 0", overrun); n_fail++; end n_tests++;
      if (valid !== 1'b1 || data_out !== 8'hB4) begin $display("FAIL ovr_retain: got valid=%b data=%h want 1 b4", valid, data_out); n_fail++; end n_tests++;
      en = 1'b1;
      ready = 1'b1;
      wait_clks(1);
      if (valid !== 1'b0) begin $display("FAIL ovr_drain: got %b want 0", valid); n_fail++; end n_tests++;
      wait_clks(BIT_CLKS);
   endtask

   task automatic test_en_drop();
      logic [DB-1:0] b;
      b = 8'h3C;
      clear_mon();
      ready = 1'b1;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(b[i]);
      rx = b[3];
      wait_clks(BIT_CLKS / 2);
      en = 1'b0;
      wait_clks(BIT_CLKS / 2);
      for (int i = 4; i < DB; i++) send_bit(b[i]);
      send_bit(1'b1);
      wait_clks(BIT_CLKS);
      en = 1'b1;
      wait_clks(BIT_CLKS);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      wait_clks(2 * BIT_CLKS);
      if (got.size() != 1) begin $display("FAIL endrop_count: got %0d want 1", got.size()); n_fail++; end n_tests++;
      if (got.size() > 0 && got[0] !== 8'h5A) begin $display("FAIL endrop_byte: got %h want 5a", got[0]); n_fail++; end n_tests++;
      if (fe_cycles != 0) begin $display("FAIL endrop_ferr: got %0d want 0", fe_cycles); n_fail++; end n_tests++;
      if (data_out !== 8'h5A) begin $display("FAIL endrop_data: got %h want 5a", data_out); n_fail++; end n_tests++;
   endtask

   task automatic test_back_to_back();
      clear_mon();
      ready = 1'b1;
      send_frame(8'h01, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFE, 1'b1, 1'b0, 1'b0);
      wait_clks(2 * BIT_CLKS);
      if (got.size() != 2) begin $display("FAIL b2b_count: got %0d want 2", got.size()); n_fail++; end n_tests++;
      if (got.size() > 0 && got[0] !== 8'h01) begin $display("FAIL b2b_first: got %h want 01", got[0]); n_fail++; end n_tests++;
      if (got.size() > 1 && got[1] !== 8'hFE) begin $display("FAIL b2b_second: got %h want fe", got[1]); n_fail++; end n_tests++;
      if (fe_cycles != 0) begin $display("FAIL b2b_ferr: got %0d want 0", fe_cycles); n_fail++; end n_tests++;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      clear_mon();
      ready = 1'b1;
      send_frame(8'hB4, 1'b1, 1'b1, 1'b1);
      wait_clks(2 * BIT_CLKS);
      if (pe_cycles != 1) begin $display("FAIL par_bad_pulse: got %0d cycles want 1", pe_cycles); n_fail++; end n_tests++;
      if (v_cycles != 0) begin $display("FAIL par_bad_valid: got %0d cycles want 0", v_cycles); n_fail++; end n_tests++;
      if (data_out !== 8'hFE) begin $display("FAIL par_bad_data: got %h want fe", data_out); n_fail++; end n_tests++;
      clear_mon();
      send_frame(8'hB4, 1'b1, 1'b1, 1'b0);
      wait_clks(2 * BIT_CLKS);
      if (pe_cycles != 0) begin $display("FAIL par_good_pulse: got %0d want 0", pe_cycles); n_fail++; end n_tests++;
      if (got.size() != 1 || data_out !== 8'hB4) begin $display("FAIL par_good_byte: got n=%0d data=%h want n=1 data=b4", got.size(), data_out); n_fail++; end n_tests++;
   endtask
`endif

   initial begin
      test_reset();
      test_good_byte();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_en_drop();
      test_back_to_back();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
